// File: rtl/vector_mem_arbiter.sv
// Shares the single byte-wide system RAM port between download, video, FDD and CPU.
// One transaction at a time: grant in IDLE, one-cycle strobe, wait for ready or timeout, ack in DONE.
module vector_mem_arbiter #(
  parameter int CPU_STARVE = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        dl_req,
  input  logic [24:0] dl_addr,
  input  logic [7:0]  dl_din,
  output logic        dl_ack,
  input  logic        vid_req,
  input  logic [15:0] vid_addr,
  output logic        vid_ack,
  input  logic        fdd_req,
  input  logic [20:0] fdd_addr,
  output logic        fdd_ack,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [19:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic        cpu_ack,
  output logic [7:0]  rdata,
  output logic [24:0] ram_addr,
  output logic [7:0]  ram_din,
  output logic        ram_we,
  output logic        ram_rd,
  input  logic [7:0]  ram_dout,
  input  logic        ram_ready,
  output logic [1:0]  owner,
  output logic        busy,
  output logic        err,
  output logic [1:0]  dbg_state
);

  // Handshake: a requester holds req (and its address/data) until its ack, which is
  // high for exactly one cycle in DONE; req may drop or re-present on the edge ending it.

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state, state_nx;
  logic [TW-1:0] wait_cnt;
  logic [2:0]    skip_cnt;
  logic          is_read;

  logic          any_req;
  logic          promote;
  logic [1:0]    win;
  logic [24:0]   win_addr;
  logic [7:0]    win_din;
  logic          win_we;
  logic          timed_out;

  always_comb begin
    any_req   = dl_req | vid_req | fdd_req | cpu_req;
    promote   = cpu_req && !dl_req && (skip_cnt == 3'(CPU_STARVE));
    timed_out = (wait_cnt == TW'(TIMEOUT));
    win       = 2'd3;
    if (dl_req)       win = 2'd0;
    else if (promote) win = 2'd3;
    else if (vid_req) win = 2'd1;
    else if (fdd_req) win = 2'd2;
    win_addr = {5'b0, cpu_addr};
    win_din  = 8'h00;
    win_we   = 1'b0;
    case (win)
      2'd0: begin
        win_addr = dl_addr;
        win_din  = dl_din;
        win_we   = 1'b1;
      end
      2'd1: win_addr = {9'b0, vid_addr};
      2'd2: win_addr = {4'b0, fdd_addr};
      default: begin
        win_addr = {5'b0, cpu_addr};
        win_din  = cpu_din;
        win_we   = cpu_we;
      end
    endcase
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = WAIT;
      WAIT:    if (ram_ready || timed_out) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state    <= IDLE;
      ram_we   <= 1'b0;
      ram_rd   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      rdata    <= '0;
      owner    <= 2'd3;
      err      <= 1'b0;
      skip_cnt <= '0;
      wait_cnt <= '0;
      is_read  <= 1'b0;
    end else begin
      state  <= state_nx;
      ram_we <= 1'b0;
      ram_rd <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner    <= win;
            ram_addr <= win_addr;
            ram_din  <= win_din;
            ram_we   <= win_we;
            ram_rd   <= !win_we;
            is_read  <= !win_we;
            wait_cnt <= '0;
            // Starvation counter only tracks grants taken while the CPU was waiting.
            if (win == 2'd3)
              skip_cnt <= '0;
            else if (cpu_req && (skip_cnt < 3'(CPU_STARVE)))
              skip_cnt <= skip_cnt + 3'd1;
          end
        end
        WAIT: begin
          if (ram_ready) begin
            if (is_read) rdata <= ram_dout;
          end else if (timed_out) begin
            rdata <= 8'hFF;
            err   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dl_ack    = (state == DONE) && (owner == 2'd0);
  assign vid_ack   = (state == DONE) && (owner == 2'd1);
  assign fdd_ack   = (state == DONE) && (owner == 2'd2);
  assign cpu_ack   = (state == DONE) && (owner == 2'd3);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule
